// File: rtl/parking_occupancy_counter.sv
// Parking gate occupancy counter: two synchronized gate sensors drive a
// direction-detecting FSM that counts cars in and out between 0 and CAPACITY.
module parking_occupancy_counter #(
    parameter int CAPACITY = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic [4:0] count,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic       full,
    output logic       empty,
    output logic       enter_pulse,
    output logic       exit_pulse,
    output logic       reject_pulse
);

    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

    localparam logic [4:0] CAP = 5'(CAPACITY);

    state_t     state;
    logic       a_meta;
    logic       b_meta;
    logic       a_s;
    logic       b_s;
    logic [1:0] pattern;

    // Both sensors are asynchronous to clk, so each gets its own two-flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_meta <= 1'b0;
            b_meta <= 1'b0;
            a_s    <= 1'b0;
            b_s    <= 1'b0;
        end else begin
            a_meta <= sensor_a;
            b_meta <= sensor_b;
            a_s    <= a_meta;
            b_s    <= b_meta;
        end
    end

    assign pattern = {a_s, b_s};

    // A car must walk the full sensor sequence; stepping back one pattern is
    // tolerated, anything else abandons the attempt without counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 5'd0;
            enter_pulse  <= 1'b0;
            exit_pulse   <= 1'b0;
            reject_pulse <= 1'b0;
        end else begin
            enter_pulse  <= 1'b0;
            exit_pulse   <= 1'b0;
            reject_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    case (pattern)
                        2'b10:   state <= EN1;
                        2'b01:   state <= EX1;
                        default: state <= IDLE;
                    endcase
                end
                EN1: begin
                    case (pattern)
                        2'b10:   state <= EN1;
                        2'b11:   state <= EN2;
                        default: state <= IDLE;
                    endcase
                end
                EN2: begin
                    case (pattern)
                        2'b11:   state <= EN2;
                        2'b01:   state <= EN3;
                        2'b10:   state <= EN1;
                        default: state <= IDLE;
                    endcase
                end
                EN3: begin
                    case (pattern)
                        2'b01: state <= EN3;
                        2'b11: state <= EN2;
                        2'b00: begin
                            state <= IDLE;
                            if (count < CAP) begin
                                count       <= count + 5'd1;
                                enter_pulse <= 1'b1;
                            end else begin
                                reject_pulse <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
                EX1: begin
                    case (pattern)
                        2'b01:   state <= EX1;
                        2'b11:   state <= EX2;
                        default: state <= IDLE;
                    endcase
                end
                EX2: begin
                    case (pattern)
                        2'b11:   state <= EX2;
                        2'b10:   state <= EX3;
                        2'b01:   state <= EX1;
                        default: state <= IDLE;
                    endcase
                end
                EX3: begin
                    case (pattern)
                        2'b10: state <= EX3;
                        2'b11: state <= EX2;
                        2'b00: begin
                            state <= IDLE;
                            if (count != 5'd0) begin
                                count      <= count - 5'd1;
                                exit_pulse <= 1'b1;
                            end else begin
                                reject_pulse <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tens_digit = 4'(count / 5'd10);
    assign ones_digit = 4'(count % 5'd10);
    assign full       = (count == CAP);
    assign empty      = (count == 5'd0);

endmodule
